// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit with a request/acknowledge memory port.
// Tolerates any number of wait states and aborts hung transactions after TIMEOUT cycles.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdr_data,
  output logic [ADDR_W-1:0] mar_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;

  // Only the low ADDR_W bits of the bus address the memory.
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus_data[DATA_W-1:ADDR_W];

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    case (state_q)
      IDLE: begin
        if (mar_in) begin
          mar_d = bus_data[ADDR_W-1:0];
        end else begin
          mar_d = mar_q;
        end
        if (mdr_in) begin
          mdr_d = bus_data;
        end else begin
          mdr_d = mdr_q;
        end
        // Read has priority; a simultaneous write is dropped and flagged.
        if (read) begin
          state_d   = RD;
          cnt_d     = {CNT_W{1'b0}};
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          err_d     = write;
        end else if (write) begin
          state_d   = WR;
          cnt_d     = {CNT_W{1'b0}};
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          err_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          if (state_q == RD) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mar_q     <= {ADDR_W{1'b0}};
      mdr_q     <= {DATA_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign mdr_data  = mdr_q;
  assign mar_data  = mar_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit, run with TIMEOUT=4.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic [31:0] bus_data;
  logic        mar_in, mdr_in, read, write;
  logic [31:0] mdr_data;
  logic [8:0]  mar_data;
  logic        busy, done, err, mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus_data(bus_data),
    .mar_in(mar_in), .mdr_in(mdr_in), .read(read), .write(write),
    .mdr_data(mdr_data), .mar_data(mar_data), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    mar_in = 1'b0; mdr_in = 1'b0; read = 1'b0; write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    clear_strobes();
    bus_data  = 32'h0;
    mem_rdata = 32'h0;
    reset     = 1'b1;
    #12;
    chk("rst_mdr", mdr_data, 32'h0);
    chk("rst_mar", {23'd0, mar_data}, 32'h0);
    chk("rst_ctl", {27'd0, busy, done, err, mem_req, mem_we}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Address truncation
    bus_data = 32'hFFFF_FE03; mar_in = 1'b1;
    tick();
    clear_strobes();
    chk("mar_trunc", {23'd0, mar_data}, 32'h003);

    // Zero-wait read
    bus_data = 32'h0000_0005; mar_in = 1'b1;
    tick();
    clear_strobes();
    read = 1'b1;
    tick();
    clear_strobes();
    chk("zr_req", {29'd0, busy, mem_req, mem_we}, 32'b110);
    chk("zr_addr", {23'd0, mem_addr}, 32'h005);
    chk("zr_done_early", {31'd0, done}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    clear_strobes();
    chk("zr_mdr", mdr_data, 32'hDEAD_BEEF);
    chk("zr_end", {28'd0, busy, done, err, mem_req}, 32'b0100);
    tick();
    chk("zr_done_pulse", {31'd0, done}, 32'h0);

    // Write with 3 wait states; MAR load in the same cycle as the strobe
    bus_data = 32'h1234_5678; mdr_in = 1'b1;
    tick();
    clear_strobes();
    bus_data = 32'h0000_01FF; mar_in = 1'b1; write = 1'b1;
    tick();
    clear_strobes();
    for (int i = 0; i < 4; i++) begin
      chk("wr_ctl", {30'd0, mem_req, mem_we}, 32'b11);
      chk("wr_addr", {23'd0, mem_addr}, 32'h1FF);
      chk("wr_wdata", mem_wdata, 32'h1234_5678);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end else begin
        chk("wr_done_early", {31'd0, done}, 32'h0);
      end
      tick();
    end
    clear_strobes();
    chk("wr_done", {29'd0, done, busy, mem_req}, 32'b100);
    chk("wr_mdr_kept", mdr_data, 32'h1234_5678);

    // Timeout with no ack: mem_req for 5 cycles
    read = 1'b1;
    tick();
    clear_strobes();
    for (int i = 0; i < 5; i++) begin
      chk("to_req", {30'd0, mem_req, done}, 32'b10);
      tick();
    end
    chk("to_end", {28'd0, done, err, busy, mem_req}, 32'b1100);
    chk("to_mdr_kept", mdr_data, 32'h1234_5678);

    // Clean read clears err
    tick();
    read = 1'b1;
    tick();
    clear_strobes();
    chk("clr_err", {31'd0, err}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    tick();
    clear_strobes();
    chk("clr_mdr", mdr_data, 32'h0BAD_CAFE);

    // Ack arriving on the final (TIMEOUT) cycle counts as success
    read = 1'b1;
    tick();
    clear_strobes();
    for (int i = 0; i < 4; i++) tick();
    chk("late_req", {31'd0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    clear_strobes();
    chk("late_end", {29'd0, done, err, mem_req}, 32'b100);
    chk("late_mdr", mdr_data, 32'h1111_2222);

    // Collision: read wins, err set; loads and strobes ignored while busy
    read = 1'b1; write = 1'b1;
    tick();
    clear_strobes();
    chk("col_ctl", {29'd0, err, mem_req, mem_we}, 32'b110);
    bus_data = 32'hAAAA_5555; mdr_in = 1'b1; mar_in = 1'b1; write = 1'b1;
    tick();
    clear_strobes();
    chk("col_mdr_frozen", mdr_data, 32'h1111_2222);
    chk("col_mar_frozen", {23'd0, mar_data}, 32'h1FF);
    chk("col_we", {31'd0, mem_we}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    clear_strobes();
    chk("col_end", {29'd0, done, err, busy}, 32'b110);
    chk("col_mdr", mdr_data, 32'h3333_4444);

    // Reset in wait state 2 of a read
    tick();
    read = 1'b1;
    tick();
    clear_strobes();
    tick();
    tick();
    chk("mid_req", {31'd0, mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {27'd0, busy, done, err, mem_req, mem_we}, 32'h0);
    chk("mid_rst_regs", {mdr_data[31:9], mdr_data[8:0] | mar_data}, 32'h0);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_6666;
    tick();
    clear_strobes();
    chk("ack_ignored", mdr_data, 32'h0);
    chk("ack_ignored_ctl", {29'd0, busy, done, mem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
